operand_fetch_unit: RTL and testbench

Parametrised successor to the single-byte operand fetch logic. Fetches 0..MAX_OPERANDS big-endian JVM bytecode operand bytes starting at an arbitrary byte PC, from a WORD_BYTES-wide instruction memory with a req/ack handshake. Handles misalignment and word-boundary crossing, which replaces the old even/odd parameter logic. Sits between the decode state machine and instruction memory; hands assembled operands to decode through a valid/ready handshake.

---
 rtl/operand_fetch_unit_pkg.sv | 18 +
 rtl/operand_fetch_unit_byte_lane_select.sv | 36 +++
 rtl/operand_fetch_unit.sv | 123 ++++++++++++
 tb/tb_operand_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared types and defaults for the operand fetch unit: the FSM state encoding
// and the default operand capacity.
package operand_fetch_unit_pkg;

  typedef enum logic [1:0] {
    OFU_IDLE  = 2'd0,
    OFU_FETCH = 2'd1,
    OFU_DONE  = 2'd2
  } ofu_state_e;

  localparam int OFU_MAX_OPERANDS = 4;

  // Bits needed to express a byte offset inside one memory word
  function automatic int ofu_off_w(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

endpackage

// File: rtl/operand_fetch_unit_byte_lane_select.sv
// Picks the operand bytes out of one memory word: starts at the byte offset and
// stops at the last lane or when no operand bytes remain.
module byte_lane_select
  import operand_fetch_unit_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int CNT_W      = 3,
  parameter int OFF_W      = 1
) (
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic [OFF_W-1:0]        offset,
  input  logic [CNT_W-1:0]        remaining,
  output logic [CNT_W-1:0]        consumed,
  output logic [8*WORD_BYTES-1:0] lane_bytes
);

  localparam int LANE_W = 8*WORD_BYTES;

  int                avail;
  int                take;
  logic [LANE_W-1:0] shifted;

  always_comb begin
    avail      = WORD_BYTES - int'(offset);
    take       = (int'(remaining) < avail) ? int'(remaining) : avail;
    consumed   = CNT_W'(take);
    lane_bytes = '0;
    shifted    = '0;
    // Lowest consumed lane lands most significant, matching big-endian order
    for (int k = 0; k < WORD_BYTES; k++) begin
      shifted = word >> (8*(int'(offset) + k));
      if (k < take) lane_bytes = (lane_bytes << 8) | LANE_W'(shifted[7:0]);
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Fetches 0..MAX_OPERANDS big-endian operand bytes from a word-wide instruction
// memory at any byte PC and hands them to decode over valid/ready.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int WORD_BYTES   = 2,
  parameter int ADDR_W       = 16,
  parameter int MAX_OPERANDS = OFU_MAX_OPERANDS,
  parameter int CNT_W        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         pc,
  input  logic [CNT_W-1:0]          operand_count,
  output logic                      busy,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [8*WORD_BYTES-1:0]   mem_rdata,
  output logic [8*MAX_OPERANDS-1:0] operands,
  output logic                      operands_valid,
  input  logic                      operands_ready,
  output logic [ADDR_W-1:0]         next_pc,
  output logic                      error
);

  localparam int                OFF_W      = ofu_off_w(WORD_BYTES);
  localparam int                LANE_W     = 8*WORD_BYTES;
  localparam int                ACC_W      = 8*MAX_OPERANDS;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0]  MAX_CNT    = CNT_W'(MAX_OPERANDS);

  ofu_state_e               state;
  logic [OFF_W-1:0]         offset;
  logic [CNT_W-1:0]         remaining;
  logic [CNT_W-1:0]         lane_consumed;
  logic [LANE_W-1:0]        lane_bytes;
  logic [ACC_W+LANE_W-1:0]  lane_wide;
  logic [ACC_W-1:0]         acc_merged;

  byte_lane_select #(
    .WORD_BYTES (WORD_BYTES),
    .CNT_W      (CNT_W),
    .OFF_W      (OFF_W)
  ) u_lane_select (
    .word       (mem_rdata),
    .offset     (offset),
    .remaining  (remaining),
    .consumed   (lane_consumed),
    .lane_bytes (lane_bytes)
  );

  // operands doubles as the accumulator; it is cleared on every accepted start
  always_comb begin
    lane_wide  = {{ACC_W{1'b0}}, lane_bytes};
    acc_merged = (operands << {lane_consumed, 3'b000}) | lane_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= OFU_IDLE;
      busy           <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      operands       <= '0;
      operands_valid <= 1'b0;
      next_pc        <= '0;
      error          <= 1'b0;
      offset         <= '0;
      remaining      <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        OFU_IDLE: begin
          if (start) begin
            if (operand_count > MAX_CNT) begin
              error <= 1'b1;
            end else begin
              busy      <= 1'b1;
              operands  <= '0;
              next_pc   <= pc + ADDR_W'(operand_count);
              offset    <= OFF_W'(pc & ALIGN_MASK);
              remaining <= operand_count;
              mem_addr  <= pc & ~ALIGN_MASK;
              if (operand_count == '0) begin
                state          <= OFU_DONE;
                operands_valid <= 1'b1;
              end else begin
                state   <= OFU_FETCH;
                mem_req <= 1'b1;
              end
            end
          end
        end
        OFU_FETCH: begin
          if (mem_ack) begin
            operands  <= acc_merged;
            offset    <= '0;
            remaining <= remaining - lane_consumed;
            if (remaining == lane_consumed) begin
              state          <= OFU_DONE;
              mem_req        <= 1'b0;
              operands_valid <= 1'b1;
            end else begin
              mem_addr <= mem_addr + WORD_STEP;
            end
          end
        end
        OFU_DONE: begin
          if (operands_ready) begin
            state          <= OFU_IDLE;
            operands_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
        default: state <= OFU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: a memory model answers requests,
// a monitor checks every handoff against expected operands queued at issue.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pc;
  logic [2:0]  operand_count;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [31:0] operands;
  logic        operands_valid;
  logic        operands_ready;
  logic [15:0] next_pc;
  logic        error;

  always #5 clk = ~clk;

  operand_fetch_unit #(
    .WORD_BYTES   (2),
    .ADDR_W       (16),
    .MAX_OPERANDS (4),
    .CNT_W        (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pc             (pc),
    .operand_count  (operand_count),
    .busy           (busy),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .operands       (operands),
    .operands_valid (operands_valid),
    .operands_ready (operands_ready),
    .next_pc        (next_pc),
    .error          (error)
  );

  typedef struct {
    logic [31:0] ops;
    logic [15:0] npc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_addr_q[$];
  bit [7:0]    mem [int];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [15:0] hold_addr = '0;
  logic        mem_ack_m = 1'b0;
  logic        stray_ack = 1'b0;

  assign mem_ack = mem_ack_m | stray_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Memory model: answers a request after ack_delay waiting cycles
  always @(negedge clk) begin
    mem_rdata = {rd(int'(mem_addr) + 1), rd(int'(mem_addr))};
    if (rst) begin
      mem_ack_m = 1'b0;
      wait_cnt  = 0;
    end else if (mem_req) begin
      if (wait_cnt > 0) check("mem_addr_hold", {16'h0, mem_addr}, {16'h0, hold_addr});
      else hold_addr = mem_addr;
      if (wait_cnt >= ack_delay) begin
        mem_ack_m = 1'b1;
        wait_cnt  = 0;
        check("mem_req_expected", (exp_addr_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_addr_q.size() != 0) check("mem_addr", {16'h0, mem_addr}, {16'h0, exp_addr_q.pop_front()});
      end else begin
        mem_ack_m = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack_m = 1'b0;
      wait_cnt  = 0;
    end
  end

  // Monitor: compares presented operands against the queue head, pops on handoff
  always @(negedge clk) begin
    #1;
    if (!rst && operands_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'h0, operands_valid}, 32'd0);
      end else begin
        check("operands", operands, exp_q[0].ops);
        check("next_pc", {16'h0, next_pc}, {16'h0, exp_q[0].npc});
        if (operands_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic expect_xfer(input logic [31:0] ops, input logic [15:0] npc);
    exp_t e;
    e.ops = ops;
    e.npc = npc;
    exp_q.push_back(e);
  endtask

  // Pulses start for one cycle; returns at the first negedge after acceptance (t1)
  task automatic issue(input logic [15:0] p, input logic [2:0] c);
    @(negedge clk);
    start = 1'b1;
    pc = p;
    operand_count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 1;
    while (!operands_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("valid_seen", {31'h0, operands_valid}, 32'd1);
    if (exp_lat > 0) check("latency", lat, exp_lat);
  endtask

  task automatic handoff_done();
    @(negedge clk);
    check("valid_after_handoff", {31'h0, operands_valid}, 32'd0);
    check("busy_after_handoff", {31'h0, busy}, 32'd0);
  endtask

  task automatic run(input logic [15:0] p, input logic [2:0] c, input logic [31:0] ops,
                     input logic [15:0] npc, input int lat);
    expect_xfer(ops, npc);
    issue(p, c);
    wait_valid(lat);
    handoff_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pc = '0;
    operand_count = '0;
    operands_ready = 1'b1;
    mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB; mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
    mem[16'h0030] = 8'h5A; mem[16'h0031] = 8'hA5;
    mem[16'h0040] = 8'h01; mem[16'h0041] = 8'h02; mem[16'h0042] = 8'h03; mem[16'h0043] = 8'h04;
    mem[16'h0050] = 8'h66; mem[16'h0051] = 8'h77;
    mem[16'h0060] = 8'h80; mem[16'h0061] = 8'h81; mem[16'h0062] = 8'h82; mem[16'h0063] = 8'h83;
    mem[16'h0080] = 8'hEE; mem[16'h0081] = 8'hEF;
    mem[16'h0090] = 8'h9A; mem[16'h0091] = 8'h9B;
    mem[16'hFFFE] = 8'hF0; mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h56;

    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_valid", {31'h0, operands_valid}, 32'd0);
    check("rst_error", {31'h0, error}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
    check("rst_operands", operands, 32'd0);
    check("rst_next_pc", {16'h0, next_pc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Misaligned start crossing a word boundary
    expect_xfer(32'h0000_BBCC, 16'h0013);
    exp_addr_q.push_back(16'h0010);
    exp_addr_q.push_back(16'h0012);
    issue(16'h0011, 3'd2);
    check("t1_busy", {31'h0, busy}, 32'd1);
    check("t1_mem_req", {31'h0, mem_req}, 32'd1);
    check("t1_mem_addr", {16'h0, mem_addr}, 32'h0010);
    wait_valid(3);
    handoff_done();

    // Aligned, single word
    exp_addr_q.push_back(16'h0020);
    run(16'h0020, 3'd2, 32'h0000_1122, 16'h0022, 2);

    // Zero operands: no memory access
    expect_xfer(32'h0, 16'h0100);
    issue(16'h0100, 3'd0);
    check("zero_mem_req", {31'h0, mem_req}, 32'd0);
    wait_valid(1);
    handoff_done();

    // Oversized count: one-cycle error, no busy
    issue(16'h0140, 3'd5);
    check("err_pulse", {31'h0, error}, 32'd1);
    check("err_busy", {31'h0, busy}, 32'd0);
    check("err_valid", {31'h0, operands_valid}, 32'd0);
    @(negedge clk);
    check("err_cleared", {31'h0, error}, 32'd0);
    check("err_busy_after", {31'h0, busy}, 32'd0);
    check("err_mem_req", {31'h0, mem_req}, 32'd0);

    // Maximum count, aligned across two words
    exp_addr_q.push_back(16'h0040);
    exp_addr_q.push_back(16'h0042);
    run(16'h0040, 3'd4, 32'h0102_0304, 16'h0044, 3);

    // Single byte in the odd lane; accumulator must be cleared from last run
    exp_addr_q.push_back(16'h0050);
    run(16'h0051, 3'd1, 32'h0000_0077, 16'h0052, 2);

    exp_addr_q.push_back(16'h0060);
    exp_addr_q.push_back(16'h0062);
    run(16'h0061, 3'd3, 32'h0081_8283, 16'h0064, 3);

    // Slow memory, slow consumer, and a start that must be ignored while busy
    ack_delay = 3;
    operands_ready = 1'b0;
    expect_xfer(32'h0000_5AA5, 16'h0032);
    exp_addr_q.push_back(16'h0030);
    issue(16'h0030, 3'd2);
    @(negedge clk);
    start = 1'b1;
    pc = 16'h0200;
    operand_count = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(-1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("valid_held", {31'h0, operands_valid}, 32'd1);
      check("req_idle_in_done", {31'h0, mem_req}, 32'd0);
    end
    operands_ready = 1'b1;
    handoff_done();
    @(negedge clk);
    check("ignored_start_busy", {31'h0, busy}, 32'd0);
    ack_delay = 0;

    // Reset in the middle of a fetch, with a stray ack afterwards
    ack_delay = 1000;
    issue(16'h0080, 3'd2);
    check("pre_rst_mem_req", {31'h0, mem_req}, 32'd1);
    check("pre_rst_mem_addr", {16'h0, mem_addr}, 32'h0080);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_async_busy", {31'h0, busy}, 32'd0);
    stray_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_mem_req", {31'h0, mem_req}, 32'd0);
      check("post_rst_busy", {31'h0, busy}, 32'd0);
      check("post_rst_valid", {31'h0, operands_valid}, 32'd0);
    end
    stray_ack = 1'b0;
    ack_delay = 0;
    exp_addr_q.push_back(16'h0090);
    run(16'h0090, 3'd2, 32'h0000_9A9B, 16'h0092, 2);

    // Address wrap at the top of memory
    exp_addr_q.push_back(16'hFFFE);
    exp_addr_q.push_back(16'h0000);
    run(16'hFFFF, 3'd3, 32'h0012_3456, 16'h0002, 3);

    repeat (2) @(negedge clk);
    check("exp_queue_drained", exp_q.size(), 32'd0);
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
